multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle control FSM for the MIPS subset: R-format (add/sub/and/or/slt), lw, sw, beq, bne.
- Sequences a shared datapath (one ALU, one memory port, IR, A/B/ALUOut registers) through fetch, decode, execute, memory and writeback.
- Computes PC write enables, including the branch-taken decision.
- Handles a variable-latency memory through a ready handshake, with a watchdog and a sticky error state.

Parameters:
- WAIT_LIMIT, 255: maximum consecutive cycles with mem_ready low in a memory state before timeout. Range 1..255.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low.
- Opcode  in  6  IR[31:26]; valid from DECODE onward.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- PCWrite  out  1  load PC.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  load IR.
- MemToReg  out  1  register write data select: 0 = ALUOut, 1 = MDR.
- RegDst  out  1  register write address select: 0 = rt, 1 = rd.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A.
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- PCSource  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- state  out  4  current state encoding, for debug.
- error  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout.

Behaviour:
- States and encodings: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, RWB 8, BRANCH 9, ERROR 15. Any other encoding is unused and returns to IDLE on the next edge.
- Reset (reset == 0, asynchronous): state = IDLE, watchdog = 0, error = 00. Every control output is 0 while in IDLE.
- Outputs are Moore decodes of state. Exceptions: PCWrite, IRWrite and the branch PCWrite are additionally qualified combinationally by mem_ready or Zero, as given below.
- IDLE -> FETCH unconditionally. This gives one idle cycle after reset release.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=0. IRWrite = PCWrite = mem_ready. If mem_ready, go to DECODE; otherwise stay in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by Opcode:
  - 0 -> EXEC
  - 35 or 43 -> MEMADR
  - 4 or 5 -> BRANCH
  - any other -> ERROR with error = 01
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD if Opcode = 35, else MEMWR.
- MEMRD: MemRead=1, IorD=1. Stay until mem_ready, then MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemToReg=1. Then FETCH.
- MEMWR: MemWrite=1, IorD=1. Stay until mem_ready, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Then RWB.
- RWB: RegWrite=1, RegDst=1, MemToReg=0. Then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=1. Then FETCH.
  - PCWrite = Zero when Opcode = 4.
  - PCWrite = ~Zero when Opcode = 5.
- MemRead and MemWrite are never asserted in the same cycle.
- Instruction latency with mem_ready always 1 (cycles from entering FETCH back to FETCH): R-format 4, lw 5, sw 4, beq/bne 3.
- Watchdog:
  - Increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready = 0.
  - Clears on mem_ready = 1 and on every state change.
  - If the count equals WAIT_LIMIT while still waiting, next state = ERROR with error = 10.
  - An access that completes on the exact cycle the count reaches WAIT_LIMIT takes precedence: completion wins, no error is flagged.
- ERROR: all control outputs 0, error held. The state is sticky; only reset leaves it.
- Reset asserted mid-instruction: immediate return to IDLE; all outputs drop to 0 asynchronously. No partial register or memory write may be issued after reset asserts.
- Opcode is sampled only in DECODE, MEMADR and BRANCH. It is treated as stable from DECODE until the next FETCH (IR is not written in between).

Test Plan:
1. reset low 3 cycles, then high, mem_ready=1 -> state 0 for one cycle after release, then 1; all outputs 0 while reset low and during IDLE.
2. Opcode=0, mem_ready=1 -> state sequence 1,2,7,8,1; PCWrite/IRWrite high only in FETCH; RegWrite=1 and RegDst=1 only in state 8; ALUOp=10 in EXEC.
3. Opcode=35, mem_ready low for 3 cycles in MEMRD -> state held at 4 for 4 cycles, then 5 with MemToReg=1 and RegWrite=1; then Opcode=43 -> sequence 1,2,3,6,1 with MemWrite=1 and IorD=1 in state 6.
4. Opcode=4 with Zero=1 -> PCWrite=1 and PCSource=1 in BRANCH. Opcode=5 with Zero=1 -> PCWrite=0. Opcode=5 with Zero=0 -> PCWrite=1.
5. Opcode=8 (unsupported) -> after DECODE, state=15 and error=01; stays there for 20 cycles regardless of inputs; reset clears to state 0 and error 00.
6. WAIT_LIMIT=4, mem_ready held 0 in FETCH -> ERROR with error=10 after 5 FETCH cycles. Repeat with mem_ready=1 on the cycle the count reaches 4 -> state 2, no error.

Source files
------------

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control/datapath signal bundle for the multi-cycle MIPS controller
interface multicycle_control_if;
   logic [5:0] Opcode;
   logic       Zero;
   logic       mem_ready;
   logic       PCWrite;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       MemToReg;
   logic       RegDst;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic       PCSource;
   logic [3:0] state;
   logic [1:0] error;

   // Controller side: observes datapath status, drives the control word
   modport master (
      input  Opcode, Zero, mem_ready,
      output PCWrite, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst,
             RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, state, error
   );

   // Datapath side: supplies status, consumes the control word
   modport slave (
      output Opcode, Zero, mem_ready,
      input  PCWrite, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst,
             RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, state, error
   );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control FSM with memory-wait watchdog
module multicycle_control #(
   parameter int WAIT_LIMIT = 255
) (
   input  logic                   clock,
   input  logic                   reset,
   multicycle_control_if.master   bus
);

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      FETCH  = 4'd1,
      DECODE = 4'd2,
      MEMADR = 4'd3,
      MEMRD  = 4'd4,
      MEMWB  = 4'd5,
      MEMWR  = 4'd6,
      EXEC   = 4'd7,
      RWB    = 4'd8,
      BRANCH = 4'd9,
      ERROR  = 4'd15
   } state_t;

   // Moore part of the control word; fetch/branch mark states whose PC/IR
   // enables are finished combinationally by mem_ready or Zero.
   typedef struct packed {
      logic       fetch;
      logic       branch;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       pc_source;
   } ctrl_t;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_OPCODE  = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

   // Control word for each state; everything not listed stays 0
   function automatic ctrl_t moore(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.fetch     = 1'b1;
            c.mem_read  = 1'b1;
            c.alu_src_b = 2'b01;
         end
         DECODE: begin
            c.alu_src_b = 2'b11;
         end
         MEMADR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         MEMRD: begin
            c.mem_read = 1'b1;
            c.iord     = 1'b1;
         end
         MEMWB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         MEMWR: begin
            c.mem_write = 1'b1;
            c.iord      = 1'b1;
         end
         EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'b10;
         end
         RWB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         BRANCH: begin
            c.branch    = 1'b1;
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'b01;
            c.pc_source = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   state_t     st;
   state_t     nxt;
   logic [1:0] err;
   logic [1:0] err_nxt;
   logic [7:0] wd;
   ctrl_t      ctrl;
   logic       waiting;
   logic       timeout;
   logic       taken;

   assign waiting = ((st == FETCH) || (st == MEMRD) || (st == MEMWR)) && !bus.mem_ready;
   assign timeout = waiting && (wd == LIMIT);

   // Next-state and error selection; a completing access always beats the watchdog
   always_comb begin
      nxt     = IDLE;
      err_nxt = err;
      case (st)
         IDLE:   nxt = FETCH;
         FETCH: begin
            if (bus.mem_ready) begin
               nxt = DECODE;
            end else if (timeout) begin
               nxt     = ERROR;
               err_nxt = ERR_TIMEOUT;
            end else begin
               nxt = FETCH;
            end
         end
         DECODE: begin
            if (bus.Opcode == OP_RTYPE) begin
               nxt = EXEC;
            end else if ((bus.Opcode == OP_LW) || (bus.Opcode == OP_SW)) begin
               nxt = MEMADR;
            end else if ((bus.Opcode == OP_BEQ) || (bus.Opcode == OP_BNE)) begin
               nxt = BRANCH;
            end else begin
               nxt     = ERROR;
               err_nxt = ERR_OPCODE;
            end
         end
         MEMADR: nxt = (bus.Opcode == OP_LW) ? MEMRD : MEMWR;
         MEMRD: begin
            if (bus.mem_ready) begin
               nxt = MEMWB;
            end else if (timeout) begin
               nxt     = ERROR;
               err_nxt = ERR_TIMEOUT;
            end else begin
               nxt = MEMRD;
            end
         end
         MEMWB:  nxt = FETCH;
         MEMWR: begin
            if (bus.mem_ready) begin
               nxt = FETCH;
            end else if (timeout) begin
               nxt     = ERROR;
               err_nxt = ERR_TIMEOUT;
            end else begin
               nxt = MEMWR;
            end
         end
         EXEC:   nxt = RWB;
         RWB:    nxt = FETCH;
         BRANCH: nxt = FETCH;
         ERROR:  nxt = ERROR;
         default: begin
            nxt     = IDLE;
            err_nxt = ERR_NONE;
         end
      endcase
   end

   // State, sticky error, watchdog and registered control word; outputs follow the next state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         st   <= IDLE;
         err  <= ERR_NONE;
         wd   <= 8'd0;
         ctrl <= '0;
      end else begin
         st   <= nxt;
         err  <= err_nxt;
         ctrl <= moore(nxt);
         if ((nxt != st) || bus.mem_ready) begin
            wd <= 8'd0;
         end else if (waiting) begin
            wd <= wd + 8'd1;
         end
      end
   end

   // Branch decision uses the opcode held in IR during BRANCH
   always_comb begin
      taken = 1'b0;
      if (bus.Opcode == OP_BEQ) begin
         taken = bus.Zero;
      end else if (bus.Opcode == OP_BNE) begin
         taken = !bus.Zero;
      end
   end

   assign bus.PCWrite  = (ctrl.fetch & bus.mem_ready) | (ctrl.branch & taken);
   assign bus.IRWrite  = ctrl.fetch & bus.mem_ready;
   assign bus.IorD     = ctrl.iord;
   assign bus.MemRead  = ctrl.mem_read;
   assign bus.MemWrite = ctrl.mem_write;
   assign bus.MemToReg = ctrl.mem_to_reg;
   assign bus.RegDst   = ctrl.reg_dst;
   assign bus.RegWrite = ctrl.reg_write;
   assign bus.ALUSrcA  = ctrl.alu_src_a;
   assign bus.ALUSrcB  = ctrl.alu_src_b;
   assign bus.ALUOp    = ctrl.alu_op;
   assign bus.PCSource = ctrl.pc_source;
   assign bus.state    = st;
   assign bus.error    = err;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized instruction-level check of multicycle_control
module tb_multicycle_control;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   multicycle_control_if bus();

   multicycle_control #(.WAIT_LIMIT(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [13:0] obs_ctrl;
   assign obs_ctrl = {bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                      bus.MemToReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                      bus.ALUSrcB, bus.ALUOp, bus.PCSource};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Control word the datapath should see in a given state, from the state table
   function automatic logic [13:0] exp_ctrl(input int s, input bit rdy, input bit z, input int op);
      logic pcw, iord, mr, mw, irw, m2r, rd, rw, sa, pcs;
      logic [1:0] sb, aop;
      {pcw, iord, mr, mw, irw, m2r, rd, rw, sa, pcs} = '0;
      sb  = 2'b00;
      aop = 2'b00;
      case (s)
         1: begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
         2: sb = 2'b11;
         3: begin sa = 1; sb = 2'b10; end
         4: begin mr = 1; iord = 1; end
         5: begin rw = 1; m2r = 1; end
         6: begin mw = 1; iord = 1; end
         7: begin sa = 1; aop = 2'b10; end
         8: begin rw = 1; rd = 1; end
         9: begin sa = 1; aop = 2'b01; pcs = 1; pcw = (op == 4) ? z : !z; end
         default: ;
      endcase
      return {pcw, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, pcs};
   endfunction

   task automatic cyc(input int exp_st, input bit rdy, input bit z, input int op,
                      input int exp_err, input string tag);
      @(negedge clock);
      bus.mem_ready = rdy;
      bus.Zero      = z;
      bus.Opcode    = 6'(op);
      #1;
      check({tag, ".state"}, 32'(bus.state), 32'(exp_st));
      check({tag, ".ctrl"},  32'(obs_ctrl),  32'(exp_ctrl(exp_st, rdy, z, op)));
      check({tag, ".error"}, 32'(bus.error), 32'(exp_err));
   endtask

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // One instruction as a path of phases: fetch (with waits), decode, then the class-specific tail
   task automatic run_instr(input int op, input bit z, input int fw, input int mw);
      string t;
      t = $sformatf("op%0d", op);
      repeat (fw) cyc(1, 0, z, op, 0, {t, ".fetchwait"});
      cyc(1, 1, z, op, 0, {t, ".fetch"});
      cyc(2, rb(), z, op, 0, {t, ".decode"});
      case (op)
         0: begin
            cyc(7, rb(), z, op, 0, {t, ".exec"});
            cyc(8, rb(), z, op, 0, {t, ".rwb"});
         end
         35: begin
            cyc(3, rb(), z, op, 0, {t, ".memadr"});
            repeat (mw) cyc(4, 0, z, op, 0, {t, ".memrdwait"});
            cyc(4, 1, z, op, 0, {t, ".memrd"});
            cyc(5, rb(), z, op, 0, {t, ".memwb"});
         end
         43: begin
            cyc(3, rb(), z, op, 0, {t, ".memadr"});
            repeat (mw) cyc(6, 0, z, op, 0, {t, ".memwrwait"});
            cyc(6, 1, z, op, 0, {t, ".memwr"});
         end
         default: cyc(9, rb(), z, op, 0, {t, ".branch"});
      endcase
   endtask

   // Assert reset away from the clock edge; outputs must drop at once
   task automatic do_reset(input string tag);
      @(negedge clock);
      bus.mem_ready = 1'b1;
      reset = 1'b0;
      #1;
      check({tag, ".rst_state"}, 32'(bus.state), 32'd0);
      check({tag, ".rst_ctrl"},  32'(obs_ctrl),  32'd0);
      check({tag, ".rst_error"}, 32'(bus.error), 32'd0);
      @(posedge clock);
      #1 reset = 1'b1;
      cyc(0, 1, 0, 0, 0, {tag, ".idle"});
   endtask

   int ops[5] = '{0, 35, 43, 4, 5};

   initial begin
      bus.mem_ready = 1'b1;
      bus.Zero      = 1'b0;
      bus.Opcode    = 6'd0;
      reset         = 1'b0;

      repeat (3) cyc(0, 1, 0, 0, 0, "reset");
      @(posedge clock);
      #1 reset = 1'b1;
      cyc(0, 1, 0, 0, 0, "idle");

      run_instr(0, 0, 0, 0);
      run_instr(35, 0, 0, 3);
      run_instr(43, 0, 0, 0);
      run_instr(4, 1, 0, 0);
      run_instr(5, 1, 0, 0);
      run_instr(5, 0, 0, 0);
      run_instr(4, 0, 0, 0);

      repeat (40) run_instr(ops[$urandom_range(0, 4)], rb(), $urandom_range(0, 3), $urandom_range(0, 3));

      // Reset in the middle of a store wait: the write must not complete
      cyc(1, 1, 0, 43, 0, "midrst.fetch");
      cyc(2, 1, 0, 43, 0, "midrst.decode");
      cyc(3, 1, 0, 43, 0, "midrst.memadr");
      cyc(6, 0, 0, 43, 0, "midrst.memwr");
      do_reset("midrst");

      // Unsupported opcode is sticky until reset
      cyc(1, 1, 0, 8, 0, "illegal.fetch");
      cyc(2, 1, 0, 8, 0, "illegal.decode");
      repeat (20) cyc(15, rb(), rb(), $urandom_range(0, 63), 1, "illegal.hold");
      do_reset("illegal");

      // Fetch timeout after WAIT_LIMIT+1 waiting cycles
      repeat (5) cyc(1, 0, 0, 0, 0, "wdfetch.wait");
      repeat (3) cyc(15, rb(), rb(), 0, 2, "wdfetch.err");
      do_reset("wdfetch");

      // Completion on the limit cycle wins over the watchdog
      repeat (4) cyc(1, 0, 0, 0, 0, "wdedge.wait");
      cyc(1, 1, 0, 0, 0, "wdedge.fetch");
      cyc(2, 0, 0, 0, 0, "wdedge.decode");
      cyc(7, 0, 0, 0, 0, "wdedge.exec");
      cyc(8, 0, 0, 0, 0, "wdedge.rwb");

      // Load data-phase timeout
      cyc(1, 1, 0, 35, 0, "wdrd.fetch");
      cyc(2, 1, 0, 35, 0, "wdrd.decode");
      cyc(3, 1, 0, 35, 0, "wdrd.memadr");
      repeat (5) cyc(4, 0, 0, 35, 0, "wdrd.wait");
      cyc(15, 1, 0, 35, 2, "wdrd.err");
      do_reset("wdrd");

      run_instr(0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
